ads1672_sample_scheduler: RTL and testbench
===========================================

Name: ads1672_sample_scheduler

Overview:
Sequences the ADS1672 capture block: issues one-cycle measure pulses on a programmable period, for a finite burst or continuously, plus software single-shot triggers. Watches each conversion for completion or timeout. Presents each captured word on a single-entry valid/ready output register with overrun and timeout status. Sits between the register/control plane and the ADS1672 capture path.

Parameters:
DATA_WIDTH, 24, ADC sample width
PERIOD_WIDTH, 16, width of trigger period (clk cycles)
BURST_WIDTH, 8, width of burst length and sample index
TIMEOUT_CYCLES, 4096, max cycles from measure to cap_valid before abort

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous, active-low reset
enable  in  1  level; rising edge starts a run, low stops further triggers
period  in  PERIOD_WIDTH  trigger-to-trigger spacing in cycles; 0 treated as 1
burst_len  in  BURST_WIDTH  samples per run; 0 = continuous while enable high
sw_trig  in  1  single-shot request, honoured only in IDLE
cap_measure  out  1  one-cycle pulse to the capture block's measure input
cap_valid  in  1  one-cycle pulse from the capture path: cap_data is valid
cap_data  in  DATA_WIDTH  captured sample
sample_data  out  DATA_WIDTH  held output sample
sample_idx  out  BURST_WIDTH  0-based index of the sample within the run
sample_valid  out  1  output register full
sample_ready  in  1  consumer accepts when valid&ready
busy  out  1  high in any state but IDLE
overrun  out  1  sticky: sample dropped because the output was full
timeout  out  1  sticky: conversion aborted by the watchdog
err_clr  in  1  clears overrun and timeout

Behaviour:
- Clock and reset: single clock clk; synchronous active-low reset rst_n. Reset is sampled only on a clk rising edge.
- Reset: state IDLE; all outputs 0; counters 0; enable edge detector cleared. Reset mid-CAPTURE abandons the conversion, and a late cap_valid is ignored.
- States: IDLE, TRIGGER, CAPTURE, WAIT_PERIOD.
- IDLE -> TRIGGER on a sampled enable rising edge (run mode) or on sw_trig with no enable edge (single mode, 1 sample). If both occur in the same cycle, run mode wins.
- TRIGGER: lasts exactly one cycle. cap_measure=1 during it, which is the cycle after the start condition is sampled. The period counter restarts here. -> CAPTURE.
- CAPTURE: the watchdog counts cycles.
  - On cap_valid, the sample is delivered.
  - At count = TIMEOUT_CYCLES with no cap_valid: set timeout, skip the sample (it still counts toward the burst).
  - Then: if the run is done (burst count reached, single mode, or enable low) -> IDLE; else -> WAIT_PERIOD.
- WAIT_PERIOD -> TRIGGER once the period counter reaches max(period,1)-1.
  - If the period has already expired at CAPTURE exit, the next TRIGGER follows immediately (the deferred trigger is not lost).
  - If enable drops while in WAIT_PERIOD -> IDLE, with no further pulse.
- Enable deasserted during CAPTURE: finish or abort the current conversion normally, then IDLE. A new run needs a fresh enable rising edge.
- Delivery: sample_valid, sample_data, and sample_idx update the cycle after cap_valid.
  - If sample_valid=1 and sample_ready=0 at that moment, the new sample is dropped, overrun is set, and the held sample is unchanged.
  - If ready is high in the same cycle, accept and load back-to-back.
  - sample_valid clears on valid&ready when no new load occurs.
- sample_idx: increments per trigger and wraps modulo 2^BURST_WIDTH in continuous mode. Reset to 0 at run start.
- err_clr: clears the sticky flags. A set event in the same cycle wins.
- period and burst_len are sampled at run start and at each TRIGGER; changes mid-wait take effect at the next TRIGGER.

Decomposition:
- Package ads1672_pkg holds:
  - the scheduler state enum (sched_state_t);
  - the default widths;
  - TIMEOUT_CYCLES default.
- One natural sub-module: ads1672_period_timer. It is a PERIOD_WIDTH counter with restart, an expired flag, and a held-expired latch for deferred triggers.

Test Plan:
- period=10, burst_len=3, enable rise; capture model returns cap_valid 4 cycles after measure, data 0xA5A5A5 -> three measure pulses spaced 10 cycles, sample_idx 0,1,2, busy low after third CAPTURE.
- period=2, capture latency 6 -> each measure is issued the cycle after the previous cap_valid (deferred trigger), no overrun, no timeout.
- sample_ready held low, burst_len=2 -> first sample 0x000001 held, second dropped, overrun=1; err_clr pulse -> overrun=0, data still 0x000001.
- TIMEOUT_CYCLES=16, model never responds, burst_len=2 -> timeout=1 sixteen cycles after first measure, second measure still issued, sample_valid stays 0.
- enable dropped mid-CAPTURE, burst_len=0 -> current sample delivered, no further cap_measure; rst_n low mid-CAPTURE -> all outputs 0 next cycle, late cap_valid ignored.
- enable low, sw_trig pulse in IDLE -> exactly one cap_measure, one sample with idx 0; sw_trig during CAPTURE ignored.

Source files
------------

// File: rtl/ads1672_pkg.sv
// ads1672_pkg
// Shared types and default sizes for the ADS1672 sample scheduler.
//   sched_state_t      : scheduler FSM states
//   *_WIDTH_DEF        : default data / period / burst widths
//   TIMEOUT_CYCLES_DEF : default conversion watchdog limit in clk cycles
package ads1672_pkg;

  localparam int DATA_WIDTH_DEF     = 24;
  localparam int PERIOD_WIDTH_DEF   = 16;
  localparam int BURST_WIDTH_DEF    = 8;
  localparam int TIMEOUT_CYCLES_DEF = 4096;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    TRIGGER     = 2'd1,
    CAPTURE     = 2'd2,
    WAIT_PERIOD = 2'd3
  } sched_state_t;

endpackage

// File: rtl/ads1672_period_timer.sv
// ads1672_period_timer
// Measures trigger-to-trigger spacing. restart is asserted in the TRIGGER
// cycle; that cycle counts as elapsed cycle 0, so expired rises exactly
// max(period,1)-1 cycles later and then stays high (held latch) until the
// next restart, so a period that ends during a long conversion is not lost.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   restart    : restart the count and sample period
//   period     : spacing in cycles, 0 treated as 1
//   expired    : spacing reached (held until restart)
module ads1672_period_timer
  import ads1672_pkg::*;
#(
  parameter int PERIOD_WIDTH = PERIOD_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    restart,
  input  logic [PERIOD_WIDTH-1:0] period,
  output logic                    expired
);

  logic [PERIOD_WIDTH-1:0] count;
  logic [PERIOD_WIDTH-1:0] term;
  logic [PERIOD_WIDTH-1:0] term_next;
  logic                    held;

  always_comb begin
    term_next = '0;
    if (period != '0) term_next = period - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      term  <= '0;
      held  <= 1'b0;
    end else if (restart) begin
      // The restart cycle itself is elapsed cycle 0, so the next cycle is 1.
      count <= PERIOD_WIDTH'(1);
      term  <= term_next;
      held  <= (term_next == '0);
    end else if (!held) begin
      if (count == term) held <= 1'b1;
      else               count <= count + 1'b1;
    end
  end

  assign expired = held | (count == term);

endmodule

// File: rtl/ads1672_sample_scheduler.sv
// ads1672_sample_scheduler
// Issues measure pulses to the ADS1672 capture block (periodic bursts,
// continuous runs, or software single shots), watches each conversion with a
// watchdog, and holds each captured word in a one-entry output register.
// Ports:
//   enable, period, burst_len, sw_trig : run control
//   cap_measure, cap_valid, cap_data   : capture block interface
//   sample_data/idx/valid, sample_ready: output register (valid/ready)
//   busy, overrun, timeout, err_clr    : status and sticky error clear
// Output handshake: a word transfers on any rising clk edge where
// sample_valid and sample_ready are both high; sample_valid stays high and
// sample_data/sample_idx stay stable until that transfer happens.
module ads1672_sample_scheduler
  import ads1672_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int PERIOD_WIDTH   = PERIOD_WIDTH_DEF,
  parameter int BURST_WIDTH    = BURST_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic [BURST_WIDTH-1:0]  burst_len,
  input  logic                    sw_trig,
  output logic                    cap_measure,
  input  logic                    cap_valid,
  input  logic [DATA_WIDTH-1:0]   cap_data,
  output logic [DATA_WIDTH-1:0]   sample_data,
  output logic [BURST_WIDTH-1:0]  sample_idx,
  output logic                    sample_valid,
  input  logic                    sample_ready,
  output logic                    busy,
  output logic                    overrun,
  output logic                    timeout,
  input  logic                    err_clr
);

  localparam int WD_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

  sched_state_t            state;
  sched_state_t            state_next;
  logic                    enable_q;
  logic                    single_q;
  logic [BURST_WIDTH-1:0]  burst_q;
  logic [BURST_WIDTH-1:0]  trig_cnt;
  logic [BURST_WIDTH-1:0]  cur_idx;
  logic [WD_WIDTH-1:0]     wd_cnt;
  logic                    period_expired;
  logic                    start_run;
  logic                    start_single;
  logic                    wd_expired;
  logic                    wd_abort;
  logic                    run_done;
  logic                    deliver;
  logic                    drop;

  // Run mode wins when an enable edge and sw_trig coincide.
  assign start_run    = enable & ~enable_q;
  assign start_single = sw_trig & ~start_run;

  // wd_cnt equals the number of cycles since the measure pulse.
  assign wd_expired = (wd_cnt == WD_WIDTH'(TIMEOUT_CYCLES));
  assign deliver    = (state == CAPTURE) & cap_valid;
  assign wd_abort   = (state == CAPTURE) & wd_expired & ~cap_valid;
  assign drop       = deliver & sample_valid & ~sample_ready;

  // trig_cnt already counts the trigger of the conversion in flight.
  assign run_done = single_q | ~enable |
                    ((burst_q != '0) & (trig_cnt == burst_q));

  assign cap_measure = (state == TRIGGER);
  assign busy        = (state != IDLE);

  ads1672_period_timer #(
    .PERIOD_WIDTH (PERIOD_WIDTH)
  ) u_period_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (state == TRIGGER),
    .period  (period),
    .expired (period_expired)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:        if (start_run || start_single) state_next = TRIGGER;
      TRIGGER:     state_next = CAPTURE;
      CAPTURE: begin
        if (cap_valid || wd_expired) begin
          if (run_done)            state_next = IDLE;
          else if (period_expired) state_next = TRIGGER;
          else                     state_next = WAIT_PERIOD;
        end
      end
      WAIT_PERIOD: begin
        if (!enable)             state_next = IDLE;
        else if (period_expired) state_next = TRIGGER;
      end
      default:     state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      enable_q <= 1'b0;
      single_q <= 1'b0;
      burst_q  <= '0;
      trig_cnt <= '0;
      cur_idx  <= '0;
      wd_cnt   <= '0;
    end else begin
      state    <= state_next;
      enable_q <= enable;
      if (state == IDLE && (start_run || start_single)) begin
        single_q <= ~start_run;
        trig_cnt <= '0;
      end
      if (state == TRIGGER) begin
        burst_q  <= burst_len;
        cur_idx  <= trig_cnt;
        trig_cnt <= trig_cnt + 1'b1;
        wd_cnt   <= WD_WIDTH'(1);
      end else if (state == CAPTURE && !wd_expired) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_valid <= 1'b0;
      sample_data  <= '0;
      sample_idx   <= '0;
      overrun      <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      if (deliver && !drop) begin
        sample_valid <= 1'b1;
        sample_data  <= cap_data;
        sample_idx   <= cur_idx;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
      // A set event in the same cycle as err_clr keeps the flag set.
      overrun <= drop | (overrun & ~err_clr);
      timeout <= wd_abort | (timeout & ~err_clr);
    end
  end

endmodule

// File: tb/tb_ads1672_sample_scheduler.sv
// tb_ads1672_sample_scheduler
// Drives runs against a cycle-level responder for the capture block and
// checks the scheduler against a transaction-level reference: measure spacing
// max(period,1) vs (latency+1), per-sample index/data through an expected
// queue, overrun/timeout sticky flags, and measure counts per run.
module tb_ads1672_sample_scheduler;

  localparam int DW = 24;
  localparam int PW = 16;
  localparam int BW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [PW-1:0] period = '0;
  logic [BW-1:0] burst_len = '0;
  logic          sw_trig = 1'b0;
  logic          cap_measure;
  logic          cap_valid = 1'b0;
  logic [DW-1:0] cap_data = '0;
  logic [DW-1:0] sample_data;
  logic [BW-1:0] sample_idx;
  logic          sample_valid;
  logic          sample_ready = 1'b0;
  logic          busy;
  logic          overrun;
  logic          timeout;
  logic          err_clr = 1'b0;

  ads1672_sample_scheduler #(
    .DATA_WIDTH     (DW),
    .PERIOD_WIDTH   (PW),
    .BURST_WIDTH    (BW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .period       (period),
    .burst_len    (burst_len),
    .sw_trig      (sw_trig),
    .cap_measure  (cap_measure),
    .cap_valid    (cap_valid),
    .cap_data     (cap_data),
    .sample_data  (sample_data),
    .sample_idx   (sample_idx),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .busy         (busy),
    .overrun      (overrun),
    .timeout      (timeout),
    .err_clr      (err_clr)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL sim_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;

  int cur_period  = 0;
  int cur_lat     = 1;
  int data_mode   = 0;   // 0 random, 1 sequence, 2 fixed A5A5A5
  int ready_mode  = 0;   // 0 ready high, 1 ready low, 2 random
  logic [DW-1:0] seq_next = '0;

  bit mon_on = 0;
  logic [BW+DW-1:0] exp_q[$];
  bit   m_full = 0;
  bit   exp_ov = 0;
  bit   exp_to = 0;
  bit   waiting = 0;
  int   age = 0;
  int   run_cnt = 0;
  logic [BW-1:0] m_idx = '0;
  int   last_meas = 0;
  int   exp_start = 0;
  int   meas_total = 0;
  int   meas_at_start = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // ---------------- capture block responder ----------------
  initial begin : responder
    int pend;
    pend = 0;
    forever begin
      @(posedge clk); #1;
      cap_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          cap_valid = 1'b1;
          case (data_mode)
            1:       begin cap_data = seq_next; seq_next = seq_next + 1'b1; end
            2:       cap_data = 24'hA5A5A5;
            default: cap_data = DW'($urandom);
          endcase
        end
      end
      if (cap_measure && cur_lat != 0) pend = cur_lat;
    end
  end

  // ---------------- consumer ----------------
  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       sample_ready = 1'b1;
        1:       sample_ready = 1'b0;
        default: sample_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // ---------------- reference model / monitor ----------------
  initial begin : monitor
    logic [BW+DW-1:0] e;
    bit drop;
    bit to_set;
    bit load;
    int peff;
    int resp;
    int gap;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        check("sample_valid", 32'(sample_valid), 32'(m_full));
        check("overrun", 32'(overrun), 32'(exp_ov));
        check("timeout", 32'(timeout), 32'(exp_to));
        if (m_full && sample_ready) begin
          if (exp_q.size() == 0) begin
            check("sample_unexpected", 32'(1), 32'(0));
          end else begin
            e = exp_q.pop_front();
            check("sample_data", 32'(sample_data), 32'(e[DW-1:0]));
            check("sample_idx", 32'(sample_idx), 32'(e[BW+DW-1:DW]));
          end
        end
        if (!rst_n) begin
          exp_q.delete();
          m_full  = 0;
          exp_ov  = 0;
          exp_to  = 0;
          waiting = 0;
        end else begin
          drop = 0; to_set = 0; load = 0;
          if (waiting) begin
            age++;
            if (cap_valid) begin load = 1; waiting = 0; end
            else if (age == TO) begin to_set = 1; waiting = 0; end
          end
          if (load) begin
            if (m_full && !sample_ready) drop = 1;
            else begin
              exp_q.push_back({m_idx, cap_data});
              m_full = 1;
            end
          end else if (m_full && sample_ready) begin
            m_full = 0;
          end
          exp_ov = drop | (exp_ov & !err_clr);
          exp_to = to_set | (exp_to & !err_clr);
          if (cap_measure) begin
            if (run_cnt == 0) begin
              check("start_latency", 32'(cyc), 32'(exp_start));
            end else begin
              peff = (cur_period == 0) ? 1 : cur_period;
              resp = (cur_lat == 0) ? TO : cur_lat;
              gap  = (peff > resp + 1) ? peff : resp + 1;
              check("meas_gap", 32'(cyc - last_meas), 32'(gap));
            end
            last_meas = cyc;
            m_idx     = BW'(run_cnt);
            run_cnt++;
            waiting   = 1;
            age       = 0;
            meas_total++;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_run(input int p, input int b, input int l, input bit with_sw);
    cur_period = p;
    cur_lat    = l;
    period     = PW'(p);
    burst_len  = BW'(b);
    tick();
    run_cnt       = 0;
    meas_at_start = meas_total;
    exp_start     = cyc + 1;
    enable        = 1'b1;
    sw_trig       = with_sw;
    tick();
    sw_trig = 1'b0;
    @(negedge clk);
    check("busy_at_trigger", 32'(busy), 32'(1));
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 0;
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      if (!busy) begin idle = 1; break; end
    end
    check("run_ends", 32'(idle), 32'(1));
  endtask

  task automatic finish_run(input int exp_meas);
    wait_idle();
    tick();
    enable     = 1'b0;
    ready_mode = 0;
    repeat (25) tick();
    check("meas_count", 32'(meas_total - meas_at_start), 32'(exp_meas));
    check("drained", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic pulse_err_clr();
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_measure"}, 32'(cap_measure), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_valid"}, 32'(sample_valid), 32'(0));
    check({tag, "_data"}, 32'(sample_data), 32'(0));
    check({tag, "_idx"}, 32'(sample_idx), 32'(0));
    check({tag, "_overrun"}, 32'(overrun), 32'(0));
    check({tag, "_timeout"}, 32'(timeout), 32'(0));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int b;
    bit seen;
    tick();
    @(negedge clk);
    check_all_zero("reset");
    tick();
    rst_n = 1'b1;
    mon_on = 1;
    repeat (3) tick();

    // Burst of 3, period 10, latency 4, fixed data.
    data_mode = 2;
    start_run(10, 3, 4, 0);
    finish_run(3);

    // Period shorter than conversion: each trigger follows cap_valid.
    data_mode = 0;
    start_run(2, 4, 6, 0);
    finish_run(4);

    // Output never accepted: second sample dropped, overrun set.
    data_mode  = 1;
    seq_next   = 24'h000001;
    ready_mode = 1;
    start_run(10, 2, 4, 0);
    wait_idle();
    @(negedge clk);
    check("ovr_flag", 32'(overrun), 32'(1));
    check("ovr_valid", 32'(sample_valid), 32'(1));
    check("ovr_held_data", 32'(sample_data), 32'h000001);
    check("ovr_held_idx", 32'(sample_idx), 32'(0));
    pulse_err_clr();
    check("ovr_cleared", 32'(overrun), 32'(0));
    check("ovr_data_kept", 32'(sample_data), 32'h000001);
    finish_run(2);

    // Capture block never responds: watchdog aborts both conversions.
    data_mode = 0;
    start_run(5, 2, 0, 0);
    wait_idle();
    @(negedge clk);
    check("to_flag", 32'(timeout), 32'(1));
    check("to_no_sample", 32'(sample_valid), 32'(0));
    pulse_err_clr();
    check("to_cleared", 32'(timeout), 32'(0));
    finish_run(2);

    // Continuous run, enable dropped during the third conversion.
    ready_mode = 2;
    start_run(8, 0, 5, 0);
    seen = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (meas_total - meas_at_start >= 3) begin seen = 1; break; end
    end
    check("cont_third_meas", 32'(seen), 32'(1));
    tick();
    tick();
    enable = 1'b0;
    finish_run(3);

    // Reset in the middle of a conversion; the late cap_valid is ignored.
    start_run(8, 0, 6, 0);
    tick();
    tick();
    rst_n  = 1'b0;
    enable = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    repeat (20) tick();
    check("midreset_no_sample", 32'(sample_valid), 32'(0));
    finish_run(1);

    // Software single shot; a second sw_trig during CAPTURE is ignored.
    ready_mode = 2;
    cur_lat    = 6;
    burst_len  = BW'(3);
    tick();
    run_cnt       = 0;
    meas_at_start = meas_total;
    exp_start     = cyc + 1;
    sw_trig       = 1'b1;
    tick();
    sw_trig = 1'b0;
    tick();
    sw_trig = 1'b1;
    tick();
    sw_trig = 1'b0;
    finish_run(1);

    // Enable edge and sw_trig together: run mode wins (burst of 2).
    start_run(6, 2, 3, 1);
    finish_run(2);

    // Randomized runs.
    for (int r = 0; r < 8; r++) begin
      data_mode  = 0;
      ready_mode = 2;
      b = $urandom_range(1, 4);
      start_run($urandom_range(0, 12), b, $urandom_range(1, 10), 0);
      finish_run(b);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
